// File: rtl/counter_tick_updown_pkg.sv
// counter_tick_updown_pkg
// Shared constants and types for the tick-driven up/down counter.
//   CLK_HZ    : board system clock frequency
//   DIV_1HZ   : prescaler divide for a 1 Hz tick
//   DIV_10HZ  : prescaler divide for a 10 Hz tick
//   dir_e     : encoding of the dir input
package counter_tick_updown_pkg;

   localparam int CLK_HZ   = 100_000_000;
   localparam int DIV_1HZ  = CLK_HZ;
   localparam int DIV_10HZ = CLK_HZ / 10;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/counter_tick_updown_tick_gen.sv
// counter_tick_updown_tick_gen
// Prescaler that produces one tick every DIV enabled clock cycles.
// Ports:
//   clk    : system clock
//   rst    : asynchronous reset, active-low
//   en     : count enable; when low the prescaler freezes (not cleared)
//   clr    : synchronous clear, restarts the period
//   tick_o : high in the cycle whose rising edge completes a period
//            (combinational from the prescaler state and en)
module counter_tick_updown_tick_gen
   import counter_tick_updown_pkg::*;
#(
   parameter int DIV = DIV_1HZ
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick_o
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] presc_reg;
   logic [PW-1:0] presc_next;

   // The tick is the edge on which the prescaler rolls over, so the
   // counter in the parent can update on that very edge.
   assign tick_o = en && (presc_reg == LAST);

   always_comb begin
      presc_next = presc_reg;
      if (clr) begin
         presc_next = '0;
      end else if (en) begin
         presc_next = (presc_reg == LAST) ? '0 : presc_reg + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_next;
      end
   end

endmodule

// File: rtl/counter_tick_updown.sv
// counter_tick_updown
// Up/down counter advanced once per prescaler tick, with wrap or
// saturate at the limits, synchronous load and one-cycle pulses.
// Ports:
//   clk      : system clock
//   rst      : asynchronous reset, active-low
//   cnt_en   : enable; low freezes prescaler and counter
//   dir      : 1 = up, 0 = down, sampled on the tick edge
//   load     : synchronous load strobe (beats a coincident tick)
//   load_val : value written on load
//   cnt      : registered counter value
//   tick     : one-cycle pulse, high while cnt shows a tick-driven value
//   tc       : one-cycle pulse, high when a tick hit a limit
module counter_tick_updown
   import counter_tick_updown_pkg::*;
#(
   parameter int WIDTH   = 6,
   parameter int DIV     = DIV_1HZ,
   parameter int RST_VAL = 1,
   parameter int WRAP    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             tick,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

   logic             tick_w;
   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic             tick_reg;
   logic             tick_next;
   logic             tc_reg;
   logic             tc_next;
   logic             at_max;
   logic             at_min;

   // Load restarts the tick period so the next tick is a full DIV later.
   counter_tick_updown_tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .en     (cnt_en),
      .clr    (load),
      .tick_o (tick_w)
   );

   assign at_max = (cnt_reg == MAX_VAL);
   assign at_min = (cnt_reg == '0);

   always_comb begin
      cnt_next  = cnt_reg;
      tick_next = 1'b0;
      tc_next   = 1'b0;
      if (load) begin
         cnt_next = load_val;
      end else if (tick_w) begin
         tick_next = 1'b1;
         if (dir_e'(dir) == DIR_UP) begin
            if (at_max) begin
               tc_next = 1'b1;
               if (WRAP != 0) begin
                  cnt_next = '0;
               end
            end else begin
               cnt_next = cnt_reg + WIDTH'(1);
            end
         end else begin
            if (at_min) begin
               tc_next = 1'b1;
               if (WRAP != 0) begin
                  cnt_next = MAX_VAL;
               end
            end else begin
               cnt_next = cnt_reg - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg  <= RST_CNT;
         tick_reg <= 1'b0;
         tc_reg   <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         tick_reg <= tick_next;
         tc_reg   <= tc_next;
      end
   end

   assign cnt  = cnt_reg;
   assign tick = tick_reg;
   assign tc   = tc_reg;

endmodule

// File: tb/tb_counter_tick_updown.sv
// tb_counter_tick_updown
// Drives a wrapping and a saturating instance with identical stimulus and
// checks both against a behavioural model through an expectation queue.
module tb_counter_tick_updown;

   localparam int W       = 3;
   localparam int DIV     = 4;
   localparam int RST_VAL = 1;
   localparam int MODV    = 1 << W;

   logic         clk;
   logic         rst;
   logic         cnt_en;
   logic         dir;
   logic         load;
   logic [W-1:0] load_val;
   logic [W-1:0] cnt_w;
   logic         tick_w;
   logic         tc_w;
   logic [W-1:0] cnt_s;
   logic         tick_s;
   logic         tc_s;

   counter_tick_updown #(.WIDTH(W), .DIV(DIV), .RST_VAL(RST_VAL), .WRAP(1)) dut_wrap (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .dir(dir), .load(load),
      .load_val(load_val), .cnt(cnt_w), .tick(tick_w), .tc(tc_w));

   counter_tick_updown #(.WIDTH(W), .DIV(DIV), .RST_VAL(RST_VAL), .WRAP(0)) dut_sat (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .dir(dir), .load(load),
      .load_val(load_val), .cnt(cnt_s), .tick(tick_s), .tc(tc_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cnt[2];
      int tck;
      int tc[2];
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Model state: index 0 = wrapping instance, 1 = saturating instance.
   int m_cnt[2];
   int m_phase;   // enabled cycles elapsed in the current tick period

   task automatic check3(input string name, input int a_cnt, input int a_tick, input int a_tc,
                         input int e_cnt, input int e_tick, input int e_tc);
      total++;
      if (a_cnt != e_cnt || a_tick != e_tick || a_tc != e_tc) begin
         bad++;
         $display("FAIL %s cycle=%0d got cnt=%0d tick=%0d tc=%0d expected cnt=%0d tick=%0d tc=%0d",
                  name, cyc, a_cnt, a_tick, a_tc, e_cnt, e_tick, e_tc);
      end else begin
         $display("ok   %s cycle=%0d cnt=%0d tick=%0d tc=%0d", name, cyc, a_cnt, a_tick, a_tc);
      end
   endtask

   // Monitor: the outputs are registered, so every edge presents a result.
   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check3("wrap", int'(cnt_w), int'(tick_w), int'(tc_w), e.cnt[0], e.tck, e.tc[0]);
         check3("sat ", int'(cnt_s), int'(tick_s), int'(tc_s), e.cnt[1], e.tck, e.tc[1]);
      end
   end

   function automatic exp_t reset_exp();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         e.cnt[i] = RST_VAL;
         e.tc[i]  = 0;
      end
      e.tck = 0;
      return e;
   endfunction

   task automatic model_reset();
      m_cnt[0] = RST_VAL;
      m_cnt[1] = RST_VAL;
      m_phase  = 0;
   endtask

   // One clock cycle of normal operation: drive inputs, predict the edge.
   task automatic step(input logic en, input logic d, input logic ld, input int lv);
      exp_t e;
      int   nxt;
      @(negedge clk);
      rst      = 1'b1;
      cnt_en   = en;
      dir      = d;
      load     = ld;
      load_val = W'(lv);
      e.tck = 0;
      e.tc[0] = 0;
      e.tc[1] = 0;
      if (ld) begin
         m_cnt[0] = lv;
         m_cnt[1] = lv;
         m_phase  = 0;
      end else if (en) begin
         m_phase++;
         if (m_phase == DIV) begin
            m_phase = 0;
            e.tck   = 1;
            for (int i = 0; i < 2; i++) begin
               nxt = m_cnt[i] + (d ? 1 : -1);
               if (nxt < 0 || nxt >= MODV) begin
                  e.tc[i] = 1;
                  if (i == 0) m_cnt[i] = (nxt + MODV) % MODV;
               end else begin
                  m_cnt[i] = nxt;
               end
            end
         end
      end
      e.cnt[0] = m_cnt[0];
      e.cnt[1] = m_cnt[1];
      exp_q.push_back(e);
   endtask

   // Assert reset between edges and confirm the outputs respond at once.
   task automatic async_reset();
      @(negedge clk);
      cnt_en = 1'b1;
      load   = 1'b0;
      #1 rst = 1'b0;
      #1;
      check3("async_rst_wrap", int'(cnt_w), int'(tick_w), int'(tc_w), RST_VAL, 0, 0);
      check3("async_rst_sat ", int'(cnt_s), int'(tick_s), int'(tc_s), RST_VAL, 0, 0);
      model_reset();
      exp_q.push_back(reset_exp());
   endtask

   task automatic run(input int n, input logic en, input logic d);
      for (int i = 0; i < n; i++) step(en, d, 1'b0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d got no finish expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cnt_en = 1'b0; dir = 1'b1; load = 1'b0; load_val = '0;
      model_reset();
      #1 rst = 1'b0;
      #1;
      check3("init_rst_wrap", int'(cnt_w), int'(tick_w), int'(tc_w), RST_VAL, 0, 0);
      check3("init_rst_sat ", int'(cnt_s), int'(tick_s), int'(tc_s), RST_VAL, 0, 0);
      repeat (2) begin
         @(negedge clk);
         exp_q.push_back(reset_exp());
      end

      // Count up from reset: 1 -> 2 -> 3 -> 4, one tick per 4 cycles.
      run(12, 1'b1, 1'b1);
      // Up limit: wrap to 0 versus saturate at 7.
      step(1'b1, 1'b1, 1'b1, 7);
      run(5, 1'b1, 1'b1);
      // Down limit: wrap to 7 versus saturate at 0.
      step(1'b1, 1'b0, 1'b1, 0);
      run(5, 1'b1, 1'b0);
      // Pause mid-period: 2 enabled, 10 paused, tick after 2 more.
      step(1'b1, 1'b1, 1'b1, 2);
      run(2, 1'b1, 1'b1);
      run(10, 1'b0, 1'b1);
      run(3, 1'b1, 1'b1);
      // Load on the cycle a tick is due: tick discarded, next one 4 later.
      step(1'b1, 1'b1, 1'b1, 3);
      run(3, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 5);
      run(5, 1'b1, 1'b1);
      // Reset mid-period with cnt=6, then first tick 4 cycles after release.
      step(1'b1, 1'b1, 1'b1, 6);
      run(2, 1'b1, 1'b1);
      async_reset();
      run(6, 1'b1, 1'b1);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(99) == 0) begin
            async_reset();
         end else begin
            step($urandom_range(3) != 0, 1'($urandom_range(1)),
                 $urandom_range(15) == 0, int'($urandom_range(MODV - 1)));
         end
      end

      @(negedge clk);
      cnt_en = 1'b0;
      load   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got pending=%0d expected pending=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
